// File: rtl/jleightcap_io_bridge_if.sv
// Pad-side and core-side signal bundle for the TinyTapeout pin bridge.
// The bridge connects through the slave modport; the pads and core use the master modport.
interface jleightcap_io_bridge_if #(
    parameter int unsigned PIN_W   = 6,
    parameter int unsigned INSTR_W = 10,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned RES_W   = 14
);
    logic [PIN_W-1:0]   pin_in;
    logic [OUT_W-1:0]   pin_out;
    logic [INSTR_W-1:0] core_instr;
    logic               core_valid;
    logic               core_ready;
    logic [RES_W-1:0]   core_result;
    logic               core_result_valid;
    logic               core_result_ready;
    logic               instr_overrun;

    modport master (
        output pin_in, core_ready, core_result, core_result_valid,
        input  pin_out, core_instr, core_valid, core_result_ready, instr_overrun
    );

    modport slave (
        input  pin_in, core_ready, core_result, core_result_valid,
        output pin_out, core_instr, core_valid, core_result_ready, instr_overrun
    );
endinterface

// File: rtl/jleightcap_io_bridge.sv
// Pin bridge: assembles SOP-framed multi-beat instructions from the pads and
// serialises wide core results onto the output pads as tagged pages.
module jleightcap_io_bridge #(
    parameter int unsigned PIN_W   = 6,
    parameter int unsigned INSTR_W = 10,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned RES_W   = 14
) (
    input logic                  clk,
    input logic                  rst,
    jleightcap_io_bridge_if.slave bus
);
    localparam int unsigned PAY_W = PIN_W - 1;
    localparam int unsigned BEATS = (INSTR_W + PAY_W - 1) / PAY_W;
    localparam int unsigned ASM_W = BEATS * PAY_W;
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam int unsigned DAT_W = OUT_W - 1;
    localparam int unsigned PAGES = (RES_W + DAT_W - 1) / DAT_W;
    localparam int unsigned SER_W = PAGES * DAT_W;
    localparam int unsigned PG_W  = $clog2(PAGES + 1);

    typedef enum logic {F_IDLE, F_COLLECT} frame_state_t;
    typedef enum logic {S_IDLE, S_SHIFT}   ser_state_t;

    // ---------------- framer ----------------
    frame_state_t       f_state, f_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ASM_W-1:0]   asm_q, asm_d;
    logic               frame_done;
    logic               sop;
    logic [PAY_W-1:0]   payload;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    logic               overrun_q;

    assign sop     = bus.pin_in[PIN_W-1];
    assign payload = bus.pin_in[PAY_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) f_state <= F_IDLE;
        else      f_state <= f_next;
    end

    always_comb begin
        f_next = f_state;
        case (f_state)
            F_IDLE:    if (sop && (BEATS > 1)) f_next = F_COLLECT;
            F_COLLECT: if (cnt_q == CNT_W'(BEATS - 1)) f_next = F_IDLE;
            default:   f_next = F_IDLE;
        endcase
    end

    // Payloads shift in from the LS end so beat 1 ends up most significant.
    always_comb begin
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        frame_done = 1'b0;
        case (f_state)
            F_IDLE: begin
                if (sop) begin
                    asm_d      = ASM_W'(payload);
                    cnt_d      = CNT_W'(1);
                    frame_done = (BEATS == 1);
                end
            end
            F_COLLECT: begin
                asm_d      = (asm_q << PAY_W) | ASM_W'(payload);
                cnt_d      = cnt_q + 1'b1;
                frame_done = (cnt_q == CNT_W'(BEATS - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            if (frame_done) begin
                if (!valid_q || bus.core_ready) begin
                    instr_q <= asm_d[INSTR_W-1:0];
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (bus.core_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.core_instr    = instr_q;
    assign bus.core_valid    = valid_q;
    assign bus.instr_overrun = overrun_q;

    // ---------------- serialiser ----------------
    ser_state_t         s_state, s_next;
    logic [PG_W-1:0]    page_q, page_d;
    logic [SER_W-1:0]   shreg_q, shreg_d;
    logic [SER_W-1:0]   word;
    logic [OUT_W-1:0]   pin_q, pin_d;
    logic               last_page;
    logic               res_ready;
    logic               accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s_state <= S_IDLE;
        else      s_state <= s_next;
    end

    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE:  if (accept) s_next = S_SHIFT;
            S_SHIFT: if (last_page && !accept) s_next = S_IDLE;
            default: s_next = S_IDLE;
        endcase
    end

    // page_q is the index of the page currently on pin_out; the shift
    // register holds only the pages still to be shown.
    always_comb begin
        last_page = (s_state == S_SHIFT) && (page_q == PG_W'(PAGES - 1));
        res_ready = (s_state == S_IDLE) || last_page;
        accept    = res_ready && bus.core_result_valid;
        word      = SER_W'(bus.core_result);
        page_d    = page_q;
        shreg_d   = shreg_q;
        pin_d     = pin_q;
        if (accept) begin
            page_d  = '0;
            shreg_d = word << DAT_W;
            pin_d   = {1'b1, word[SER_W-1 -: DAT_W]};
        end else if (last_page) begin
            pin_d   = '0;
        end else if (s_state == S_SHIFT) begin
            page_d  = page_q + 1'b1;
            shreg_d = shreg_q << DAT_W;
            pin_d   = {1'b0, shreg_q[SER_W-1 -: DAT_W]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_q  <= '0;
            shreg_q <= '0;
            pin_q   <= '0;
        end else begin
            page_q  <= page_d;
            shreg_q <= shreg_d;
            pin_q   <= pin_d;
        end
    end

    assign bus.pin_out           = pin_q;
    assign bus.core_result_ready = res_ready;
endmodule

// File: tb/tb_jleightcap_io_bridge.sv
// Directed bench for the pin bridge: default configuration plus a narrow
// PIN_W=4/INSTR_W=8/OUT_W=4/RES_W=8 instance checked against a small model.
module tb_jleightcap_io_bridge;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    jleightcap_io_bridge_if #(.PIN_W(6), .INSTR_W(10), .OUT_W(8), .RES_W(14)) bus_a ();
    jleightcap_io_bridge_if #(.PIN_W(4), .INSTR_W(8),  .OUT_W(4), .RES_W(8))  bus_b ();

    jleightcap_io_bridge #(.PIN_W(6), .INSTR_W(10), .OUT_W(8), .RES_W(14)) u_dut (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    jleightcap_io_bridge #(.PIN_W(4), .INSTR_W(8), .OUT_W(4), .RES_W(8)) u_small (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0] p0, p1, p2;
        logic [8:0] cat;
        logic [7:0] r;
        logic [8:0] w;

        rst = 1'b0;
        bus_a.pin_in = '0; bus_a.core_ready = 1'b1;
        bus_a.core_result = '0; bus_a.core_result_valid = 1'b0;
        bus_b.pin_in = '0; bus_b.core_ready = 1'b1;
        bus_b.core_result = '0; bus_b.core_result_valid = 1'b0;
        #12;
        check("rst_instr",   bus_a.core_instr, 0);
        check("rst_valid",   bus_a.core_valid, 0);
        check("rst_pin_out", bus_a.pin_out, 0);
        check("rst_overrun", bus_a.instr_overrun, 0);
        check("rst_rready",  bus_a.core_result_ready, 1);
        tick();
        rst = 1'b1;

        // basic two-beat frame
        bus_a.pin_in = 6'b110101; tick();
        check("basic_mid_valid", bus_a.core_valid, 0);
        bus_a.pin_in = 6'b000011; tick();
        bus_a.pin_in = '0;
        check("basic_instr", bus_a.core_instr, 10'h2A3);
        check("basic_valid", bus_a.core_valid, 1);
        tick();
        check("basic_valid_drop", bus_a.core_valid, 0);

        // non-SOP beats ignored in idle; SOP inside a frame is payload
        bus_a.pin_in = 6'b011111; tick(); tick(); tick();
        check("idle_no_frame", bus_a.core_valid, 0);
        bus_a.pin_in = 6'b100001; tick();
        bus_a.pin_in = 6'b111110; tick();
        bus_a.pin_in = '0;
        check("sop_payload_instr", bus_a.core_instr, 10'h03E);
        check("sop_payload_valid", bus_a.core_valid, 1);
        tick();

        // overrun: second frame dropped while first is still pending
        bus_a.core_ready = 1'b0;
        bus_a.pin_in = 6'b110101; tick();
        bus_a.pin_in = 6'b000011; tick();
        bus_a.pin_in = 6'b101010; tick();
        bus_a.pin_in = 6'b010101; tick();
        bus_a.pin_in = '0;
        check("ovr_instr",   bus_a.core_instr, 10'h2A3);
        check("ovr_valid",   bus_a.core_valid, 1);
        check("ovr_flag",    bus_a.instr_overrun, 1);
        tick();
        check("ovr_sticky",  bus_a.instr_overrun, 1);

        // same scenario, but the core accepts on the completing edge
        do_reset();
        bus_a.pin_in = 6'b110101; tick();
        bus_a.pin_in = 6'b000011; tick();
        bus_a.pin_in = 6'b101010; tick();
        bus_a.pin_in = 6'b010101; bus_a.core_ready = 1'b1; tick();
        bus_a.pin_in = '0;
        check("noovr_instr", bus_a.core_instr, 10'h155);
        check("noovr_valid", bus_a.core_valid, 1);
        check("noovr_flag",  bus_a.instr_overrun, 0);
        tick();
        check("noovr_drop",  bus_a.core_valid, 0);

        // single result paging
        bus_a.core_result = 14'h2ABC; bus_a.core_result_valid = 1'b1;
        check("pg_ready_idle", bus_a.core_result_ready, 1);
        tick();
        bus_a.core_result_valid = 1'b0;
        check("pg_page0", bus_a.pin_out, 8'hD5);
        check("pg_ready_busy", bus_a.core_result_ready, 0);
        tick();
        check("pg_page1", bus_a.pin_out, 8'h3C);
        check("pg_ready_last", bus_a.core_result_ready, 1);
        tick();
        check("pg_idle", bus_a.pin_out, 8'h00);

        // back-to-back results, no gap
        bus_a.core_result = 14'h2ABC; bus_a.core_result_valid = 1'b1; tick();
        check("b2b_p0", bus_a.pin_out, 8'hD5);
        bus_a.core_result = 14'h0001; tick();
        check("b2b_p1", bus_a.pin_out, 8'h3C);
        tick();
        bus_a.core_result_valid = 1'b0;
        check("b2b_p2", bus_a.pin_out, 8'h80);
        tick();
        check("b2b_p3", bus_a.pin_out, 8'h01);
        tick();
        check("b2b_idle", bus_a.pin_out, 8'h00);

        // asynchronous reset mid-frame and mid-page
        bus_a.pin_in = 6'b110101;
        bus_a.core_result = 14'h2ABC; bus_a.core_result_valid = 1'b1; tick();
        bus_a.core_result_valid = 1'b0;
        check("mid_page0", bus_a.pin_out, 8'hD5);
        #2 rst = 1'b0;
        #1;
        check("arst_pin_out", bus_a.pin_out, 0);
        check("arst_instr",   bus_a.core_instr, 0);
        check("arst_valid",   bus_a.core_valid, 0);
        check("arst_rready",  bus_a.core_result_ready, 1);
        tick();
        bus_a.pin_in = 6'b000011;
        rst = 1'b1;
        tick();
        check("post_rst_partial", bus_a.core_valid, 0);
        check("post_rst_pin", bus_a.pin_out, 0);
        bus_a.pin_in = 6'b110101; tick();
        bus_a.pin_in = 6'b000011; tick();
        bus_a.pin_in = '0;
        check("post_rst_instr", bus_a.core_instr, 10'h2A3);
        check("post_rst_valid", bus_a.core_valid, 1);
        tick();

        // narrow instance: BEATS=3, top bit of beat 1 discarded
        bus_b.pin_in = 4'b1111; tick();
        bus_b.pin_in = 4'b0000; tick();
        bus_b.pin_in = 4'b0001; tick();
        bus_b.pin_in = '0;
        check("nar_instr", bus_b.core_instr, 8'hC1);
        check("nar_valid", bus_b.core_valid, 1);
        tick();

        // narrow instance: PAGES=3
        bus_b.core_result = 8'hA5; bus_b.core_result_valid = 1'b1; tick();
        bus_b.core_result_valid = 1'b0;
        check("nar_p0", bus_b.pin_out, 4'hA);
        tick();
        check("nar_p1", bus_b.pin_out, 4'h4);
        tick();
        check("nar_p2", bus_b.pin_out, 4'h5);
        tick();
        check("nar_idle", bus_b.pin_out, 4'h0);

        // narrow instance: random frames and results against a model
        for (int i = 0; i < 6; i++) begin
            p0 = 3'($urandom_range(0, 7));
            p1 = 3'($urandom_range(0, 7));
            p2 = 3'($urandom_range(0, 7));
            cat = {p0, p1, p2};
            bus_b.pin_in = {1'b1, p0}; tick();
            bus_b.pin_in = {1'($urandom_range(0, 1)), p1}; tick();
            bus_b.pin_in = {1'($urandom_range(0, 1)), p2}; tick();
            bus_b.pin_in = '0;
            check("rnd_instr", bus_b.core_instr, cat[7:0]);
            check("rnd_valid", bus_b.core_valid, 1);

            r = 8'($urandom_range(0, 255));
            w = {1'b0, r};
            bus_b.core_result = r; bus_b.core_result_valid = 1'b1; tick();
            bus_b.core_result_valid = 1'b0;
            check("rnd_p0", bus_b.pin_out, {1'b1, w[8:6]});
            tick();
            check("rnd_p1", bus_b.pin_out, {1'b0, w[5:3]});
            tick();
            check("rnd_p2", bus_b.pin_out, {1'b0, w[2:0]});
            tick();
            check("rnd_idle", bus_b.pin_out, 4'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
